mem_access_ctrl: RTL

//  Sequencer and 2-way arbiter in front of the memory address register and data memory.

---
 rtl/mem_ctrl_pkg.sv | 23 ++
 rtl/mem_arb.sv | 46 ++++
 rtl/mem_access_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the memory access controller slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_ctrl_pkg;

  localparam int DEF_AW       = 13;
  localparam int DEF_DW       = 16;
  localparam int DEF_MAX_WAIT = 15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DRIVE  = 3'd2,
    ACCESS = 3'd3,
    RESP   = 3'd4
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb.sv
// 2-way arbiter: fetch vs data request -> one-hot grant, combinational.
// Latency: grant in the same cycle as the request while en is high.
// Backpressure: grants only when en is high; a losing request simply stays pending.
// Config: MEM_ARB_RR_EN selects round-robin (adds clk/rst and a last-grant pointer);
//         otherwise fixed priority with data always ahead of fetch.
// Ports: en (grant window), if_req/d_req in, if_gnt/d_gnt out.
module mem_arb
  import mem_ctrl_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic en,
  input  logic if_req,
  input  logic d_req,
  output logic if_gnt,
  output logic d_gnt
);

`ifdef MEM_ARB_RR_EN
  // Remembers who was granted last; reset value IF means D is favoured first.
  owner_e last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OWN_IF;
    end else if (d_gnt) begin
      last_q <= OWN_D;
    end else if (if_gnt) begin
      last_q <= OWN_IF;
    end
  end

  always_comb begin
    d_gnt  = en & d_req & (~if_req | (last_q == OWN_IF));
    if_gnt = en & if_req & ~d_gnt;
  end
`else
  always_comb begin
    d_gnt  = en & d_req;
    if_gnt = en & if_req & ~d_req;
  end
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer sharing one MAR and memory port between fetch and data requesters.
// Latency: gnt -> rvalid is 3 cycles plus ACCESS cycles (min 4, max 3+MAX_WAIT).
// Backpressure: one transaction at a time; requests wait in IDLE, mem_ack is awaited up to MAX_WAIT cycles.
// Config: MEM_ARB_RR_EN enables round-robin arbitration (see mem_arb).
// Ports: if_* fetch request/response, d_* data request/response, mar_* MAR strobes/address,
//        mem_* memory port, busy high whenever not IDLE.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mar_wr,
  output logic          mar_re,
  output logic [AW-1:0] mar_din,
  output logic          mem_en,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  state_e        state_q, state_d;
  owner_e        owner_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          we_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic          arb_en;
  logic          gnt_if;
  logic          gnt_d;
  logic          timeout;
  logic          resp;

  // Grants are combinational, so gate them with rst to keep every output low during reset.
  assign arb_en = (state_q == IDLE) && !rst;

  mem_arb u_arb (
`ifdef MEM_ARB_RR_EN
    .clk    (clk),
    .rst    (rst),
`endif
    .en     (arb_en),
    .if_req (if_req),
    .d_req  (d_req),
    .if_gnt (gnt_if),
    .d_gnt  (gnt_d)
  );

  assign timeout = (cnt_q == CW'(MAX_WAIT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_if || gnt_d) state_d = LOAD;
      LOAD:    state_d = DRIVE;
      DRIVE:   state_d = ACCESS;
      ACCESS:  if (mem_ack || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_IF;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (gnt_if || gnt_d) begin
        owner_q <= gnt_d ? OWN_D : OWN_IF;
        addr_q  <= gnt_d ? d_addr : if_addr;
        we_q    <= gnt_d & d_we;
        wdata_q <= gnt_d ? d_wdata : '0;
      end
      // Wait counter runs only in ACCESS and sticks at MAX_WAIT rather than wrapping.
      if (state_q == ACCESS) begin
        if (cnt_q != CW'(MAX_WAIT)) cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= '0;
      end
      // An ack on the final wait cycle still counts as success.
      if (state_q == ACCESS) begin
        if (mem_ack) begin
          rdata_q <= we_q ? '0 : mem_rdata;
          err_q   <= 1'b0;
        end else if (timeout) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign resp      = (state_q == RESP);
  assign if_gnt    = gnt_if;
  assign d_gnt     = gnt_d;
  assign if_rvalid = resp && (owner_q == OWN_IF);
  assign d_rvalid  = resp && (owner_q == OWN_D);
  assign if_rdata  = if_rvalid ? rdata_q : '0;
  assign d_rdata   = d_rvalid ? rdata_q : '0;
  assign if_err    = if_rvalid & err_q;
  assign d_err     = d_rvalid & err_q;
  assign mar_wr    = (state_q == LOAD);
  assign mar_re    = (state_q == DRIVE);
  assign mar_din   = mar_wr ? addr_q : '0;
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign busy      = (state_q != IDLE);

endmodule
